// File: rtl/status_if.sv
// status_if: execute-stage flag interface between the pipeline and the status register.
interface status_if #(parameter int WIDTH = 32);
    logic [3:0]       exe_cmd;
    logic [WIDTH-1:0] val1;
    logic [WIDTH-1:0] val2;
    logic             s_bit;
    logic             valid;
    logic             stall;
    logic             flush;
    logic             exc_entry;
    logic             exc_return;
    logic [3:0]       status_reg;
    logic [3:0]       flags_next;
    logic [3:0]       saved_flags;
    logic             flags_written;
    modport master (
        output exe_cmd, val1, val2, s_bit, valid, stall, flush, exc_entry, exc_return,
        input  status_reg, flags_next, saved_flags, flags_written
    );
    modport slave (
        input  exe_cmd, val1, val2, s_bit, valid, stall, flush, exc_entry, exc_return,
        output status_reg, flags_next, saved_flags, flags_written
    );
endinterface

// File: rtl/status_register.sv
// status_register: computes N/Z/C/V for the execute-stage op and holds the architectural
// and exception-saved copies of the {N,Z,C,V} flags.
module status_register #(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst_n,
    status_if.slave bus
);
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    logic [WIDTH:0] a, b, res;
    logic           c_in, arith, sub, flag_op, upd;
    logic           n, z, c, v, a_m, b_m, r_m;
    assign a    = {1'b0, bus.val1};
    assign b    = {1'b0, bus.val2};
    // Carry-in always comes from the registered flags, never the forwarded ones.
    assign c_in = bus.status_reg[1];
    always_comb begin
        res     = '0;
        arith   = 1'b0;
        sub     = 1'b0;
        flag_op = 1'b1;
        case (bus.exe_cmd)
            CMD_MOV: res = b;
            CMD_MVN: res = {1'b0, ~bus.val2};
            CMD_ADD: begin res = a + b; arith = 1'b1; end
            CMD_ADC: begin res = a + b + {{WIDTH{1'b0}}, c_in}; arith = 1'b1; end
            CMD_SUB: begin res = a - b; arith = 1'b1; sub = 1'b1; end
            CMD_SBC: begin res = a - b - {{WIDTH{1'b0}}, ~c_in}; arith = 1'b1; sub = 1'b1; end
            CMD_AND: res = {1'b0, bus.val1 & bus.val2};
            CMD_ORR: res = {1'b0, bus.val1 | bus.val2};
            CMD_EOR: res = {1'b0, bus.val1 ^ bus.val2};
            default: flag_op = 1'b0;
        endcase
    end
    assign a_m = bus.val1[WIDTH-1];
    assign b_m = bus.val2[WIDTH-1];
    assign r_m = res[WIDTH-1];
    assign n   = r_m;
    assign z   = (res[WIDTH-1:0] == '0);
    // Subtract carry is "no borrow": bit WIDTH of the zero-extended difference is the borrow.
    assign c   = arith ? (sub ? ~res[WIDTH] : res[WIDTH]) : c_in;
    assign v   = arith ? ((sub ? (a_m != b_m) : (a_m == b_m)) && (r_m != a_m)) : bus.status_reg[0];
    assign bus.flags_next = flag_op ? {n, z, c, v} : bus.status_reg;
    assign upd = bus.valid & bus.s_bit & ~bus.stall & ~bus.flush;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.status_reg    <= 4'b0000;
            bus.saved_flags   <= 4'b0000;
            bus.flags_written <= 1'b0;
        end else begin
            bus.flags_written <= bus.exc_return | (~bus.exc_entry & upd);
            if (bus.exc_return)
                bus.status_reg <= bus.saved_flags;
            else if (bus.exc_entry)
                bus.saved_flags <= bus.status_reg;
            else if (upd)
                bus.status_reg <= bus.flags_next;
        end
    end
endmodule

// File: tb/tb_status_register.sv
// tb_status_register: directed vector table, async-reset sequence and randomized
// stimulus checked against an arithmetic reference model of the flag rules.
module tb_status_register;
    localparam logic [3:0] NOP = 4'h0, MOV = 4'h1, ADD = 4'h2, ADC = 4'h3, SUB = 4'h4,
                           SBC = 4'h5, AND = 4'h6, ORR = 4'h7, EOR = 4'h8, MVN = 4'h9;
    // ctrl = {s_bit, valid, stall, flush, exc_entry, exc_return}
    localparam logic [5:0] U = 6'b110000;
    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [5:0]  ctrl;
        logic [3:0]  est;
        logic [3:0]  esv;
        logic        ew;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [3:0] m_st = 4'b0, m_sv = 4'b0;
    logic       m_w = 1'b0;
    vec_t tbl[$];
    status_if #(.WIDTH(32)) bus();
    status_register #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [3:0] model_flags(input logic [3:0] cmd, input logic [31:0] v1, v2,
                                               input logic [3:0] cur);
        longint u, sg;
        logic [31:0] r;
        logic c, v, is_add;
        c = cur[1];
        v = cur[0];
        u = 0;
        sg = 0;
        is_add = 1'b0;
        case (cmd)
            ADD, ADC: begin
                is_add = 1'b1;
                u  = longint'(v1) + longint'(v2) + ((cmd == ADC && c) ? 1 : 0);
                sg = longint'($signed(v1)) + longint'($signed(v2)) + ((cmd == ADC && c) ? 1 : 0);
            end
            SUB, SBC: begin
                u  = longint'(v1) - longint'(v2) - ((cmd == SBC && !c) ? 1 : 0);
                sg = longint'($signed(v1)) - longint'($signed(v2)) - ((cmd == SBC && !c) ? 1 : 0);
            end
            MOV: r = v2;
            MVN: r = ~v2;
            AND: r = v1 & v2;
            ORR: r = v1 | v2;
            EOR: r = v1 ^ v2;
            default: return cur;
        endcase
        if (cmd inside {ADD, ADC, SUB, SBC}) begin
            r = u[31:0];
            c = is_add ? (u >= 64'sd4294967296) : (u >= 0);
            v = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
        end
        return {r[31], r == 32'h0, c, v};
    endfunction
    task automatic drive(input logic [3:0] cmd, input logic [31:0] v1, v2, input logic [5:0] k);
        bus.exe_cmd = cmd;
        bus.val1 = v1;
        bus.val2 = v2;
        {bus.s_bit, bus.valid, bus.stall, bus.flush, bus.exc_entry, bus.exc_return} = k;
    endtask
    // Called at a negedge: applies inputs, checks forwarding, clocks once, checks registers.
    task automatic step(input logic [3:0] cmd, input logic [31:0] v1, v2, input logic [5:0] k);
        logic [3:0] nx;
        logic upd;
        drive(cmd, v1, v2, k);
        nx = model_flags(cmd, v1, v2, m_st);
        upd = k[5] && k[4] && !k[3] && !k[2];
        #1 check("flags_next", bus.flags_next, nx);
        @(posedge clk);
        if (k[0]) begin m_st = m_sv; m_w = 1'b1; end
        else if (k[1]) begin m_sv = m_st; m_w = 1'b0; end
        else if (upd) begin m_st = nx; m_w = 1'b1; end
        else m_w = 1'b0;
        @(negedge clk);
        check("status_reg", bus.status_reg, m_st);
        check("saved_flags", bus.saved_flags, m_sv);
        check("flags_written", bus.flags_written, m_w);
    endtask
    function automatic vec_t mk(input logic [3:0] c, input logic [31:0] a, b, input logic [5:0] k,
                                input logic [3:0] es, ev, input logic ew);
        mk = '{c, a, b, k, es, ev, ew};
    endfunction
    function automatic logic [31:0] rv();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction
    initial begin
        drive(NOP, 0, 0, 6'b0);
        repeat (2) @(negedge clk);
        check("reset status_reg", bus.status_reg, 4'b0000);
        check("reset saved_flags", bus.saved_flags, 4'b0000);
        check("reset flags_written", bus.flags_written, 1'b0);
        rst_n = 1'b1;
        tbl.push_back(mk(ADD, 32'h7FFFFFFF, 1, U, 4'b1001, 4'b0000, 1'b1));
        tbl.push_back(mk(ADD, 1, 1, 6'b110010, 4'b1001, 4'b1001, 1'b0));
        tbl.push_back(mk(SUB, 5, 5, U, 4'b0110, 4'b1001, 1'b1));
        tbl.push_back(mk(ADD, 1, 1, 6'b110001, 4'b1001, 4'b1001, 1'b1));
        tbl.push_back(mk(SUB, 5, 5, U, 4'b0110, 4'b1001, 1'b1));
        tbl.push_back(mk(SUB, 3, 5, U, 4'b1000, 4'b1001, 1'b1));
        tbl.push_back(mk(SUB, 5, 5, U, 4'b0110, 4'b1001, 1'b1));
        tbl.push_back(mk(ADC, 32'hFFFFFFFF, 0, U, 4'b0110, 4'b1001, 1'b1));
        tbl.push_back(mk(ADD, 32'h7FFFFFFF, 1, U, 4'b1001, 4'b1001, 1'b1));
        tbl.push_back(mk(AND, 32'hFFFFFFFF, 0, U, 4'b0101, 4'b1001, 1'b1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(SUB, 5, 5, 6'b111000, 4'b0101, 4'b1001, 1'b0));
        tbl.push_back(mk(SUB, 5, 5, U, 4'b0110, 4'b1001, 1'b1));
        tbl.push_back(mk(ADD, 32'h7FFFFFFF, 1, 6'b110100, 4'b0110, 4'b1001, 1'b0));
        tbl.push_back(mk(ADD, 32'h7FFFFFFF, 1, 6'b100000, 4'b0110, 4'b1001, 1'b0));
        tbl.push_back(mk(ADD, 32'h7FFFFFFF, 1, 6'b010000, 4'b0110, 4'b1001, 1'b0));
        tbl.push_back(mk(SUB, 3, 5, U, 4'b1000, 4'b1001, 1'b1));
        tbl.push_back(mk(ADD, 32'hFFFFFFFF, 1, U, 4'b0110, 4'b1001, 1'b1));
        tbl.push_back(mk(SUB, 3, 5, 6'b110011, 4'b1001, 4'b1001, 1'b1));
        tbl.push_back(mk(NOP, 5, 5, U, 4'b1001, 4'b1001, 1'b1));
        tbl.push_back(mk(SBC, 5, 3, U, 4'b0010, 4'b1001, 1'b1));
        tbl.push_back(mk(SBC, 5, 5, U, 4'b0110, 4'b1001, 1'b1));
        tbl.push_back(mk(ORR, 32'h80000000, 0, U, 4'b1010, 4'b1001, 1'b1));
        tbl.push_back(mk(EOR, 32'hFFFFFFFF, 32'hFFFFFFFF, U, 4'b0110, 4'b1001, 1'b1));
        tbl.push_back(mk(MVN, 0, 0, U, 4'b1010, 4'b1001, 1'b1));
        tbl.push_back(mk(MOV, 0, 0, U, 4'b0110, 4'b1001, 1'b1));
        tbl.push_back(mk(SBC, 32'h80000000, 1, U, 4'b0011, 4'b1001, 1'b1));
        tbl.push_back(mk(ADC, 32'h7FFFFFFF, 0, U, 4'b1001, 4'b1001, 1'b1));
        foreach (tbl[i]) begin
            step(tbl[i].cmd, tbl[i].v1, tbl[i].v2, tbl[i].ctrl);
            check($sformatf("vec%0d status", i), bus.status_reg, tbl[i].est);
            check($sformatf("vec%0d saved", i), bus.saved_flags, tbl[i].esv);
            check($sformatf("vec%0d written", i), bus.flags_written, tbl[i].ew);
        end
        // Asynchronous reset between edges, held across an edge with a live update.
        step(SUB, 5, 5, U);
        check("pre-reset status", bus.status_reg, 4'b0110);
        drive(ADD, 32'h7FFFFFFF, 1, U);
        #3 rst_n = 1'b0;
        #1;
        check("async status", bus.status_reg, 4'b0000);
        check("async saved", bus.saved_flags, 4'b0000);
        check("async written", bus.flags_written, 1'b0);
        @(negedge clk);
        check("held status", bus.status_reg, 4'b0000);
        check("held written", bus.flags_written, 1'b0);
        m_st = 4'b0;
        m_sv = 4'b0;
        m_w = 1'b0;
        rst_n = 1'b1;
        step(SUB, 3, 5, U);
        check("post-reset status", bus.status_reg, 4'b1000);
        for (int i = 0; i < 400; i++)
            step(4'($urandom_range(0, 15)), rv(), rv(),
                 {$urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
